// File: rtl/dma_word_reader_if.sv
// Bus bundle for dma_word_reader: the word-read request channel toward the
// memory responder and the valid/ready output stream toward the consumer.
interface dma_word_reader_if #(
    parameter int RAM_WID      = 32,
    parameter int RAM_WORD_WID = 16
);
    logic [RAM_WID-1:0]      ram_dma_addr;
    logic                    ram_read;
    logic [RAM_WORD_WID-1:0] ram_word;
    logic                    ram_valid;
    logic [RAM_WORD_WID-1:0] out_word;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output ram_dma_addr,
        output ram_read,
        input  ram_word,
        input  ram_valid,
        output out_word,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  ram_dma_addr,
        input  ram_read,
        output ram_word,
        output ram_valid,
        input  out_word,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/dma_word_reader.sv
// DMA initiator: fetches word_count 16-bit words from base_addr upward over the
// ram_read/ram_valid interface and presents them on a one-word valid/ready stream.
module dma_word_reader #(
    parameter int RAM_WID        = 32,
    parameter int RAM_WORD_WID   = 16,
    parameter int CNT_WID        = 12,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_CNTR_LEN   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [RAM_WID-1:0] base_addr,
    input  logic [CNT_WID-1:0] word_count,
    input  logic               loop_en,
    output logic               busy,
    output logic               done,
    output logic               timeout_err,
    dma_word_reader_if.master  bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_RELEASE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Last REQ cycle count before the request is abandoned.
    localparam logic [TMO_CNTR_LEN-1:0] TMO_LAST = TMO_CNTR_LEN'(TIMEOUT_CYCLES - 1);

    state_t                  state_r, state_s;
    logic [RAM_WID-1:0]      addr_r, addr_s;
    logic                    ram_read_r, ram_read_s;
    logic [RAM_WORD_WID-1:0] out_word_r, out_word_s;
    logic                    out_valid_r, out_valid_s;
    logic                    busy_r, busy_s;
    logic                    done_r, done_s;
    logic                    tmo_err_r, tmo_err_s;
    logic [CNT_WID-1:0]      idx_r, idx_s;
    logic [TMO_CNTR_LEN-1:0] tmo_r, tmo_s;
    logic [RAM_WID-1:0]      base_r, base_s;
    logic [CNT_WID-1:0]      count_r, count_s;
    logic                    loop_r, loop_s;
    logic                    is_last_s;
    logic                    drain_go_s;

    // Byte offset of a word index, zero-extended and wrapping with the address width.
    function automatic logic [RAM_WID-1:0] word_offset(input logic [CNT_WID-1:0] idx);
        logic [RAM_WID-1:0] off;
        off              = {RAM_WID{1'b0}};
        off[CNT_WID:0]   = {idx, 1'b0};
        return off;
    endfunction

    assign is_last_s  = (idx_r == (count_r - CNT_WID'(1)));
    assign drain_go_s = (~out_valid_r) | bus.out_ready;

    // Next-state and next-output decode; abort overrides every state.
    always_comb begin
        state_s     = state_r;
        addr_s      = addr_r;
        ram_read_s  = ram_read_r;
        out_word_s  = out_word_r;
        out_valid_s = out_valid_r;
        done_s      = 1'b0;
        tmo_err_s   = tmo_err_r;
        idx_s       = idx_r;
        tmo_s       = tmo_r;
        base_s      = base_r;
        count_s     = count_r;
        loop_s      = loop_r;

        if (out_valid_r && bus.out_ready) begin
            out_valid_s = 1'b0;
        end else begin
            out_valid_s = out_valid_r;
        end

        if (abort) begin
            state_s     = ST_IDLE;
            ram_read_s  = 1'b0;
            out_valid_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        base_s    = base_addr;
                        count_s   = word_count;
                        loop_s    = loop_en;
                        tmo_err_s = 1'b0;
                        idx_s     = {CNT_WID{1'b0}};
                        tmo_s     = {TMO_CNTR_LEN{1'b0}};
                        if (word_count == {CNT_WID{1'b0}}) begin
                            state_s = ST_DONE;
                        end else begin
                            state_s    = ST_REQ;
                            ram_read_s = 1'b1;
                            addr_s     = base_addr;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (bus.ram_valid) begin
                        out_word_s  = bus.ram_word;
                        out_valid_s = 1'b1;
                        ram_read_s  = 1'b0;
                        state_s     = ST_RELEASE;
                    end else if (tmo_r == TMO_LAST) begin
                        ram_read_s = 1'b0;
                        tmo_err_s  = 1'b1;
                        state_s    = ST_IDLE;
                    end else begin
                        tmo_s = tmo_r + TMO_CNTR_LEN'(1);
                    end
                end
                ST_RELEASE: begin
                    // Never re-request while the responder still drives valid.
                    if (!bus.ram_valid) begin
                        state_s = ST_DRAIN;
                    end else begin
                        state_s = ST_RELEASE;
                    end
                end
                ST_DRAIN: begin
                    if (drain_go_s) begin
                        if (!is_last_s) begin
                            idx_s      = idx_r + CNT_WID'(1);
                            addr_s     = base_r + word_offset(idx_r + CNT_WID'(1));
                            tmo_s      = {TMO_CNTR_LEN{1'b0}};
                            ram_read_s = 1'b1;
                            state_s    = ST_REQ;
                        end else if (loop_r) begin
                            idx_s      = {CNT_WID{1'b0}};
                            addr_s     = base_r;
                            tmo_s      = {TMO_CNTR_LEN{1'b0}};
                            ram_read_s = 1'b1;
                            state_s    = ST_REQ;
                        end else begin
                            state_s = ST_DONE;
                        end
                    end else begin
                        state_s = ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s    = ST_IDLE;
                    ram_read_s = 1'b0;
                end
            endcase
        end

        busy_s = (state_s != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            addr_r      <= {RAM_WID{1'b0}};
            ram_read_r  <= 1'b0;
            out_word_r  <= {RAM_WORD_WID{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            tmo_err_r   <= 1'b0;
            idx_r       <= {CNT_WID{1'b0}};
            tmo_r       <= {TMO_CNTR_LEN{1'b0}};
            base_r      <= {RAM_WID{1'b0}};
            count_r     <= {CNT_WID{1'b0}};
            loop_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            addr_r      <= addr_s;
            ram_read_r  <= ram_read_s;
            out_word_r  <= out_word_s;
            out_valid_r <= out_valid_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            tmo_err_r   <= tmo_err_s;
            idx_r       <= idx_s;
            tmo_r       <= tmo_s;
            base_r      <= base_s;
            count_r     <= count_s;
            loop_r      <= loop_s;
        end
    end

    assign bus.ram_dma_addr = addr_r;
    assign bus.ram_read     = ram_read_r;
    assign bus.out_word     = out_word_r;
    assign bus.out_valid    = out_valid_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign timeout_err      = tmo_err_r;

endmodule

// File: tb/tb_dma_word_reader.sv
// Directed bench for dma_word_reader with a behavioural word responder and a
// monitor logging request addresses, accepted stream words and done pulses.
module tb_dma_word_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] base_addr;
    logic [11:0] word_count;
    logic        loop_en;
    logic        busy;
    logic        done;
    logic        timeout_err;

    dma_word_reader_if #(.RAM_WID(32), .RAM_WORD_WID(16)) bus ();

    dma_word_reader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .base_addr   (base_addr),
        .word_count  (word_count),
        .loop_en     (loop_en),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .bus         (bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] addr_log[$];
    logic [15:0] word_log[$];
    int          done_cnt   = 0;
    int          proto_viol = 0;
    int          resp_delay = 12;
    bit          resp_mute  = 1'b0;
    int          resp_cnt   = 0;
    logic        prev_read  = 1'b0;
    logic [31:0] prev_addr  = 32'h0;

    function automatic logic [15:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C ^ a[31:16];
    endfunction

    // Monitor samples first, then the responder updates its outputs.
    always @(negedge clk) begin
        if (rst) begin
            prev_read     = 1'b0;
            resp_cnt      = 0;
            bus.ram_valid = 1'b0;
        end else begin
            if (bus.ram_read && !prev_read) begin
                addr_log.push_back(bus.ram_dma_addr);
                if (bus.ram_valid) proto_viol++;
            end
            if (bus.ram_read && prev_read && bus.ram_dma_addr !== prev_addr) proto_viol++;
            if (bus.out_valid && bus.out_ready) word_log.push_back(bus.out_word);
            if (done) done_cnt++;
            prev_read = bus.ram_read;
            prev_addr = bus.ram_dma_addr;
            if (bus.ram_valid) begin
                bus.ram_valid = 1'b0;
            end else if (bus.ram_read && !resp_mute) begin
                resp_cnt++;
                if (resp_cnt >= resp_delay) begin
                    bus.ram_valid = 1'b1;
                    bus.ram_word  = mem_word(bus.ram_dma_addr);
                    resp_cnt      = 0;
                end
            end else if (!bus.ram_read) begin
                resp_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] b, input logic [11:0] c, input logic l);
        tick();
        base_addr  = b;
        word_count = c;
        loop_en    = l;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int n);
        n = 0;
        while (busy === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; base_addr = 32'h0; word_count = 12'h0;
        loop_en = 1'b0; bus.out_ready = 1'b0; bus.ram_valid = 1'b0; bus.ram_word = 16'h0;
        repeat (3) tick();
        checks++; if (bus.ram_read !== 1'b0) begin errors++; $display("FAIL reset_ram_read: got %b expected 0", bus.ram_read); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
        checks++; if (bus.ram_dma_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", bus.ram_dma_addr); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int a0 = addr_log.size();
        int w0 = word_log.size();
        int d0 = done_cnt;
        int v0 = proto_viol;
        int n;
        logic [31:0] ea;
        resp_delay = 12; bus.out_ready = 1'b1;
        do_start(32'h12340, 12'd4, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise: got %b expected 1", busy); end
        wait_idle(400, n);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: busy %b after %0d cycles, expected 0", busy, n); end
        checks++; if (addr_log.size() - a0 != 4) begin errors++; $display("FAIL basic_nreq: got %0d expected 4", addr_log.size() - a0); end
        checks++; if (word_log.size() - w0 != 4) begin errors++; $display("FAIL basic_nword: got %0d expected 4", word_log.size() - w0); end
        if (addr_log.size() - a0 == 4 && word_log.size() - w0 == 4) begin
            for (int i = 0; i < 4; i++) begin
                ea = 32'h12340 + 32'(2 * i);
                checks++; if (addr_log[a0+i] !== ea) begin errors++; $display("FAIL basic_addr[%0d]: got %h expected %h", i, addr_log[a0+i], ea); end
                checks++; if (word_log[w0+i] !== mem_word(ea)) begin errors++; $display("FAIL basic_word[%0d]: got %h expected %h", i, word_log[w0+i], mem_word(ea)); end
            end
        end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done: got %0d pulses expected 1", done_cnt - d0); end
        checks++; if (proto_viol != v0) begin errors++; $display("FAIL basic_protocol: got %0d violations expected 0", proto_viol - v0); end
    endtask

    task automatic test_backpressure();
        int a0 = addr_log.size();
        int w0 = word_log.size();
        int d0 = done_cnt;
        int n = 0;
        logic [15:0] w;
        logic [31:0] ea;
        resp_delay = 12; bus.out_ready = 1'b0;
        do_start(32'h12340, 12'd4, 1'b0);
        while (bus.out_valid !== 1'b1 && n < 100) begin tick(); n++; end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_first_valid: got %b expected 1", bus.out_valid); end
        w = bus.out_word;
        checks++; if (w !== mem_word(32'h12340)) begin errors++; $display("FAIL bp_first_word: got %h expected %h", w, mem_word(32'h12340)); end
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_word !== w || bus.ram_read !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall[%0d]: got valid=%b word=%h read=%b expected 1/%h/0", c, bus.out_valid, bus.out_word, bus.ram_read, w);
            end
        end
        bus.out_ready = 1'b1;
        wait_idle(400, n);
        checks++; if (addr_log.size() - a0 != 4 || word_log.size() - w0 != 4) begin errors++; $display("FAIL bp_counts: got %0d req %0d words expected 4 4", addr_log.size() - a0, word_log.size() - w0); end
        if (addr_log.size() - a0 == 4 && word_log.size() - w0 == 4) begin
            for (int i = 0; i < 4; i++) begin
                ea = 32'h12340 + 32'(2 * i);
                checks++; if (word_log[w0+i] !== mem_word(ea)) begin errors++; $display("FAIL bp_word[%0d]: got %h expected %h", i, word_log[w0+i], mem_word(ea)); end
            end
        end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL bp_done: got %0d pulses expected 1", done_cnt - d0); end
    endtask

    task automatic test_loop_abort();
        int a0 = addr_log.size();
        int w0 = word_log.size();
        int d0 = done_cnt;
        int n = 0;
        logic [31:0] ea;
        resp_delay = 3; bus.out_ready = 1'b1;
        do_start(32'h12340, 12'd2, 1'b1);
        while (word_log.size() - w0 < 7 && n < 300) begin tick(); n++; end
        checks++; if (word_log.size() - w0 < 7 || addr_log.size() - a0 < 7) begin errors++; $display("FAIL loop_words: got %0d words expected at least 7", word_log.size() - w0); end
        if (word_log.size() - w0 >= 7 && addr_log.size() - a0 >= 7) begin
            for (int i = 0; i < 7; i++) begin
                ea = (i % 2 == 0) ? 32'h12340 : 32'h12342;
                checks++; if (addr_log[a0+i] !== ea) begin errors++; $display("FAIL loop_addr[%0d]: got %h expected %h", i, addr_log[a0+i], ea); end
                checks++; if (word_log[w0+i] !== mem_word(ea)) begin errors++; $display("FAIL loop_word[%0d]: got %h expected %h", i, word_log[w0+i], mem_word(ea)); end
            end
        end
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL loop_no_done: got %0d pulses expected 0", done_cnt - d0); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL loop_busy: got %b expected 1", busy); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (bus.ram_read !== 1'b0) begin errors++; $display("FAIL abort_read: got %b expected 0", bus.ram_read); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b expected 0", bus.out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        repeat (4) tick();
        checks++; if (done_cnt != d0 || busy !== 1'b0) begin errors++; $display("FAIL abort_quiet: got done=%0d busy=%b expected 0 0", done_cnt - d0, busy); end
    endtask

    task automatic test_timeout();
        int d0 = done_cnt;
        int w0;
        int n = 0;
        resp_mute = 1'b1; bus.out_ready = 1'b1;
        do_start(32'h100, 12'd3, 1'b0);
        while (bus.ram_read === 1'b1 && n < 400) begin tick(); n++; end
        checks++; if (n != 255) begin errors++; $display("FAIL tmo_cycles: got %0d expected 255", n); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_err_set: got %b expected 1", timeout_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy: got %b expected 0", busy); end
        repeat (3) tick();
        checks++; if (done_cnt != d0 || timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got done=%0d err=%b expected 0 1", done_cnt - d0, timeout_err); end
        resp_mute = 1'b0; resp_delay = 2;
        w0 = word_log.size();
        do_start(32'h200, 12'd1, 1'b0);
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_err_clear: got %b expected 0", timeout_err); end
        wait_idle(100, n);
        checks++; if (word_log.size() - w0 != 1 || done_cnt - d0 != 1) begin errors++; $display("FAIL tmo_recover: got %0d words %0d done expected 1 1", word_log.size() - w0, done_cnt - d0); end
        else begin
            checks++; if (word_log[w0] !== mem_word(32'h200)) begin errors++; $display("FAIL tmo_recover_word: got %h expected %h", word_log[w0], mem_word(32'h200)); end
        end
    endtask

    task automatic test_zero_and_busy_start();
        int a0 = addr_log.size();
        int d0 = done_cnt;
        int n;
        do_start(32'h4000, 12'd0, 1'b0);
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL zero_c1: got busy=%b done=%b expected 1 0", busy, done); end
        tick();
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_c2: got done=%b busy=%b expected 1 0", done, busy); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_c3: got done=%b expected 0", done); end
        checks++; if (addr_log.size() != a0) begin errors++; $display("FAIL zero_no_read: got %0d requests expected 0", addr_log.size() - a0); end
        a0 = addr_log.size(); d0 = done_cnt;
        resp_delay = 4; bus.out_ready = 1'b1;
        do_start(32'h2000, 12'd3, 1'b0);
        repeat (5) tick();
        base_addr = 32'h5000; word_count = 12'd1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(200, n);
        checks++; if (addr_log.size() - a0 != 3) begin errors++; $display("FAIL busy_start_count: got %0d requests expected 3", addr_log.size() - a0); end
        else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (addr_log[a0+i] !== 32'h2000 + 32'(2 * i)) begin errors++; $display("FAIL busy_start_addr[%0d]: got %h expected %h", i, addr_log[a0+i], 32'h2000 + 32'(2 * i)); end
            end
        end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL busy_start_done: got %0d pulses expected 1", done_cnt - d0); end
    endtask

    task automatic test_async_reset();
        int a0, w0, d0, n;
        resp_delay = 20; bus.out_ready = 1'b1;
        do_start(32'h12340, 12'd4, 1'b0);
        checks++; if (bus.ram_read !== 1'b1) begin errors++; $display("FAIL arst_pre_read: got %b expected 1", bus.ram_read); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.ram_read !== 1'b0) begin errors++; $display("FAIL arst_read: got %b expected 0", bus.ram_read); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b expected 0", bus.out_valid); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL arst_busy_done: got %b %b expected 0 0", busy, done); end
        repeat (2) tick();
        rst = 1'b0;
        resp_delay = 5;
        a0 = addr_log.size(); w0 = word_log.size(); d0 = done_cnt;
        do_start(32'h3000, 12'd2, 1'b0);
        wait_idle(200, n);
        checks++; if (addr_log.size() - a0 != 2 || word_log.size() - w0 != 2) begin errors++; $display("FAIL arst_after_counts: got %0d req %0d words expected 2 2", addr_log.size() - a0, word_log.size() - w0); end
        else begin
            checks++; if (addr_log[a0+1] !== 32'h3002) begin errors++; $display("FAIL arst_after_addr: got %h expected 00003002", addr_log[a0+1]); end
            checks++; if (word_log[w0+1] !== mem_word(32'h3002)) begin errors++; $display("FAIL arst_after_word: got %h expected %h", word_log[w0+1], mem_word(32'h3002)); end
        end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL arst_after_done: got %0d pulses expected 1", done_cnt - d0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_loop_abort();
        test_timeout();
        test_zero_and_busy_start();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
